keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner with debounce, multi-key rejection, optional auto-repeat and a valid/ready key-code output. It drives one-hot column strobes, samples row returns, and delivers one code per debounced press to downstream logic such as the display/mode controller of the e155 ASIC. It generalises the fixed 4x4 scan to arbitrary matrix size, scan rate and debounce depth.

## Interface
- NROWS, 4: row inputs (≥1)
- NCOLS, 4: column outputs (≥1)
- SCAN_DIV, 16: clock cycles each column is driven (≥2)
- DEBOUNCE, 4: consecutive identical frames to accept a press or a release (≥1)
- REPEAT_DLY, 32: frames held before the first repeat; 0 disables auto-repeat
- REPEAT_RATE, 8: frames between subsequent repeats (≥1)
- ph1  in  1  single system clock, rising-edge
- reset  in  1  asynchronous active-low reset
- rows  in  NROWS  row returns, 1 = key closed in driven column
- columns  out  NCOLS  one-hot column strobe, active-high
- key_code  out  CW = $clog2(NROWS*NCOLS)  code = col*NROWS + row
- key_valid  out  1  key_code holds an undelivered code
- key_ready  in  1  consumer accepts code when key_valid & key_ready
- overflow  out  1  sticky: a code was dropped; cleared by reset or overflow_clr
- overflow_clr  in  1  single-cycle clear of overflow

## Operation
- Scan: cycle counter 0..SCAN_DIV-1 per column; column index advances 0..NCOLS-1 and wraps. rows sampled on the last cycle of each column into frame bit [col*NROWS+row].
- Frame end (last cycle of column NCOLS-1): frame classified NONE (0 bits), SINGLE (1 bit, code = its index), MULTI (≥2 bits).
- FSM states IDLE, PRESS_DB, HELD, RELEASE_DB; evaluated only at frame end.
- IDLE: SINGLE → PRESS_DB, cand=code, cnt=1 (if DEBOUNCE=1, emit and go HELD directly). NONE/MULTI → stay.
- PRESS_DB: SINGLE same cand → cnt+1; at cnt==DEBOUNCE emit cand, go HELD, rpt=0. SINGLE other code → restart with new cand, cnt=1. NONE/MULTI → IDLE.
- HELD: SINGLE cand → rpt+1; if REPEAT_DLY≠0 emit when rpt==REPEAT_DLY, then every REPEAT_RATE frames thereafter. MULTI or SINGLE other code → stay, rpt frozen, no emit. NONE → RELEASE_DB, cnt=1 (DEBOUNCE=1: straight to IDLE).
- RELEASE_DB: NONE → cnt+1; at DEBOUNCE → IDLE. Anything else → HELD, rpt kept.
- Output register: emit loads key_code, sets key_valid. key_valid&key_ready clears it unless an emit occurs the same cycle (then new code loads, key_valid stays 1). Emit while key_valid&~key_ready: code dropped, register unchanged, overflow set.
- overflow_clr and a new overflow event in the same cycle: overflow stays 1.

## Timing
- Reset values: columns = 1 (column 0), key_code = 0, key_valid = 0, overflow = 0; counters, frame, FSM = IDLE.
- Frame length NCOLS*SCAN_DIV cycles; first full frame starts the cycle after reset deasserts.
- key_valid rises the cycle after the frame-end edge on which the accepting condition holds; press latency = DEBOUNCE frames from first full frame containing the key.
- key_code stable while key_valid=1 and no handshake.
- Reset asserted mid-scan or mid-handshake: all state clears asynchronously; pending code lost, no overflow.
- columns changes only on column-boundary edges; never zero, never multi-hot.

## Structure
- Package keypad_pkg: FSM enum (IDLE, PRESS_DB, HELD, RELEASE_DB), frame-class enum (NONE, SINGLE, MULTI), code-width function.
- Sub-module keypad_col_scan: cycle counter, column ring, frame capture register, frame_done pulse. Top holds classifier, FSM, repeat counter, output register.

## Test plan
Defaults for bench: NROWS=4, NCOLS=4, SCAN_DIV=4, DEBOUNCE=3, REPEAT_DLY=4, REPEAT_RATE=2 (frame = 16 cycles).
- Reset: columns=0001, key_valid=0, overflow=0; columns steps 0001→0010→0100→1000→0001 every 4 cycles.
- Hold row 2 in column 1 for 5 frames, key_ready=1 → one code 6, key_valid high exactly 1 cycle, 3 frames after press start.
- Hold key 6 for 12 frames → initial emit, repeats at held-frame 4, 6, 8, ...; release for 3 frames → IDLE, no further codes.
- Bounce: key 6 for 2 frames, off 1, on 2 → no emit; two keys (codes 6, 9) held 5 frames → no emit.
- key_ready=0, two separate presses (codes 3 then 12) → key_code=3 retained, overflow=1; overflow_clr pulse → overflow=0.
- Assert reset mid-PRESS_DB and while key_valid=1 → all outputs return to reset values immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the matrix keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} kp_state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_e;

  // Keeps a 1x1 matrix from producing a zero-width code bus.
  function automatic int code_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - column strobe ring, row capture and frame-end pulse
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int NROWS    = 4,
  parameter int NCOLS    = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                   ph1,
  input  logic                   reset,
  input  logic [NROWS-1:0]       rows,
  output logic [NCOLS-1:0]       columns,
  output logic [NROWS*NCOLS-1:0] frame,
  output logic                   frame_done
);

  localparam int CTW  = $clog2(SCAN_DIV);
  localparam int COLW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  logic [CTW-1:0]           r_cyc;
  logic [COLW-1:0]          r_col;
  logic [NCOLS-1:0]         r_columns;
  logic [NROWS*NCOLS-1:0]   r_frame;
  logic                     w_col_last;
  logic                     w_frame_last;

  assign w_col_last   = (r_cyc == CTW'(SCAN_DIV - 1));
  assign w_frame_last = w_col_last && (r_col == COLW'(NCOLS - 1));
  assign columns      = r_columns;
  assign frame_done   = w_frame_last;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_cyc     <= '0;
      r_col     <= '0;
      r_columns <= NCOLS'(1);
      r_frame   <= '0;
    end else if (w_col_last) begin
      r_cyc <= '0;
      r_frame[int'(r_col)*NROWS +: NROWS] <= rows;
      if (w_frame_last) begin
        r_col     <= '0;
        r_columns <= NCOLS'(1);
      end else begin
        r_col     <= r_col + COLW'(1);
        r_columns <= r_columns << 1;
      end
    end else begin
      r_cyc <= r_cyc + CTW'(1);
    end
  end

  // Last column is merged live so the classifier sees the whole frame on the frame-end edge.
  always_comb begin
    frame = r_frame;
    frame[int'(r_col)*NROWS +: NROWS] = rows;
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - debounced keypad scanner with auto-repeat and valid/ready output
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS       = 4,
  parameter int NCOLS       = 4,
  parameter int SCAN_DIV    = 16,
  parameter int DEBOUNCE    = 4,
  parameter int REPEAT_DLY  = 32,
  parameter int REPEAT_RATE = 8,
  localparam int CW         = code_width(NROWS * NCOLS)
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic [NROWS-1:0] rows,
  output logic [NCOLS-1:0] columns,
  output logic [CW-1:0]    key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int NK   = NROWS * NCOLS;
  localparam int CNTW = $clog2(DEBOUNCE + 1);
  localparam int RW   = $clog2(REPEAT_DLY + REPEAT_RATE + 1);

  logic [NK-1:0]  w_frame;
  logic           w_frame_done;
  logic [1:0]     w_hits;
  logic [CW-1:0]  w_idx;
  frame_class_e   w_class;

  kp_state_e      r_state, w_state_nxt;
  logic [CW-1:0]  r_cand, w_cand_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [RW-1:0]  r_rpt, w_rpt_nxt, w_rpt_inc;
  logic           w_emit;

  logic [CW-1:0]  r_code;
  logic           r_valid;
  logic           r_ovf;

  keypad_col_scan #(.NROWS(NROWS), .NCOLS(NCOLS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .ph1        (ph1),
    .reset      (reset),
    .rows       (rows),
    .columns    (columns),
    .frame      (w_frame),
    .frame_done (w_frame_done)
  );

  always_comb begin
    w_hits = 2'd0;
    w_idx  = '0;
    for (int i = 0; i < NK; i++) begin
      if (w_frame[i]) begin
        w_idx = CW'(i);
        if (w_hits != 2'd2) w_hits = w_hits + 2'd1;
      end
    end
    case (w_hits)
      2'd0:    w_class = NONE;
      2'd1:    w_class = SINGLE;
      default: w_class = MULTI;
    endcase
  end

  assign w_cnt_inc = r_cnt + CNTW'(1);
  assign w_rpt_inc = r_rpt + RW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_rpt_nxt   = r_rpt;
    w_emit      = 1'b0;
    if (w_frame_done) begin
      case (r_state)
        IDLE: begin
          if (w_class == SINGLE) begin
            w_cand_nxt = w_idx;
            if (DEBOUNCE == 1) begin
              w_emit      = 1'b1;
              w_state_nxt = HELD;
              w_rpt_nxt   = '0;
            end else begin
              w_state_nxt = PRESS_DB;
              w_cnt_nxt   = CNTW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (w_class != SINGLE) begin
            w_state_nxt = IDLE;
          end else if (w_idx != r_cand) begin
            w_cand_nxt = w_idx;
            w_cnt_nxt  = CNTW'(1);
          end else if (w_cnt_inc == CNTW'(DEBOUNCE)) begin
            w_emit      = 1'b1;
            w_state_nxt = HELD;
            w_rpt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HELD: begin
          if (w_class == NONE) begin
            w_state_nxt = (DEBOUNCE == 1) ? IDLE : RELEASE_DB;
            w_cnt_nxt   = CNTW'(1);
          end else if (w_class == SINGLE && w_idx == r_cand && REPEAT_DLY != 0) begin
            // After the first repeat the counter cycles DLY..DLY+RATE-1.
            if (w_rpt_inc == RW'(REPEAT_DLY + REPEAT_RATE)) begin
              w_emit    = 1'b1;
              w_rpt_nxt = RW'(REPEAT_DLY);
            end else begin
              w_emit    = (w_rpt_inc == RW'(REPEAT_DLY));
              w_rpt_nxt = w_rpt_inc;
            end
          end
        end
        RELEASE_DB: begin
          if (w_class != NONE) begin
            w_state_nxt = HELD;
          end else if (w_cnt_inc == CNTW'(DEBOUNCE)) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_rpt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rpt   <= w_rpt_nxt;
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_emit && (!r_valid || key_ready)) begin
        r_code  <= w_cand_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && key_ready) begin
        r_valid <= 1'b0;
      end
      if (w_emit && r_valid && !key_ready) r_ovf <= 1'b1;
      else if (overflow_clr)               r_ovf <= 1'b0;
    end
  end

  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign overflow  = r_ovf;

endmodule
